// File: rtl/regfile_32x64.sv
// ---------------------------------------------------------------------------
// regfile_32x64
//
// Architectural integer register file for the pipelined ARM core.
// 32 x 64-bit registers, one write port, two combinational read ports.
// Index ZERO_REG (X31) is the zero register (XZR). It always reads 0, and
// writes to it are dropped.
//
// The write address is decoded into a one-hot enable vector built from a
// 1-to-2 / 2-to-4 / 2-to-4 decoder tree. Each register loads only when its
// own enable bit is set. The vector is exported so that per-register write
// activity can be observed.
//
// Reads are combinational and include a write-through bypass. A register
// being written in the current cycle shows the incoming wr_data before the
// clock edge. This removes the WB->ID hazard without a stall.
//
// Ports
//   clk        in   1       core clock, rising edge
//   reset_n    in   1       asynchronous active-low reset, clears every register
//   wr_en      in   1       write-back enable (RegWrite from WB)
//   wr_addr    in   5       destination register index
//   wr_data    in   DATA_W  write-back data
//   rd_addr_a  in   5       read port A index (Rn)
//   rd_addr_b  in   5       read port B index (Rm/Rt)
//   rd_data_a  out  DATA_W  read port A data
//   rd_data_b  out  DATA_W  read port B data
//   wr_onehot  out  NREGS   decoded per-register write enable
// ---------------------------------------------------------------------------
module regfile_32x64 #(
  parameter int DATA_W   = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [NREGS-1:0]  wr_onehot
);

  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // -------------------------------------------------------------------------
  // Decoder tree primitives
  // -------------------------------------------------------------------------
  function automatic logic [1:0] dec_1to2(input logic s);
    logic [1:0] y;
    y    = 2'b00;
    y[s] = 1'b1;
    return y;
  endfunction

  function automatic logic [3:0] dec_2to4(input logic [1:0] s);
    logic [3:0] y;
    y    = 4'b0000;
    y[s] = 1'b1;
    return y;
  endfunction

  // -------------------------------------------------------------------------
  // Write-address decode
  // -------------------------------------------------------------------------
  // Split the address into three fields: the top bit selects a half, the
  // middle pair selects a quad, and the bottom pair selects a register.
  logic [1:0] dec_hi;
  logic [3:0] dec_mid;
  logic [3:0] dec_lo;

  always_comb begin
    dec_hi  = dec_1to2(wr_addr[4]);
    dec_mid = dec_2to4(wr_addr[3:2]);
    dec_lo  = dec_2to4(wr_addr[1:0]);
  end

  // Each enable bit is wr_en ANDed with one output of each decoder.
  // When wr_en is 0, every bit resolves to 0, even if the address bits are
  // unknown. This keeps the bypass path below free of X propagation.
  always_comb begin
    wr_onehot = '0;
    for (int i = 0; i < NREGS; i++) begin
      logic [ADDR_W-1:0] idx;
      idx          = ADDR_W'(i);
      wr_onehot[i] = wr_en & dec_hi[idx[4]] & dec_mid[idx[3:2]] & dec_lo[idx[1:0]];
    end
    // XZR is never written.
    wr_onehot[ZERO_REG] = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // Each register has its own load enable, and wr_data fans out to all of
  // them. Reset takes priority over any write in progress. The XZR slot is
  // never enabled, so it stays at its reset value of 0.
  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_onehot[i]) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  // Priority, highest first: zero register, then same-cycle write bypass,
  // then stored value. The bypass is selected by the decoded enable bit of
  // the addressed register. That bit is already 0 for XZR and when wr_en is
  // low.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (wr_onehot[rd_addr_a]) begin
      rd_data_a = wr_data;
    end
    if (rd_addr_a == ZERO_ADDR) begin
      rd_data_a = '0;
    end
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (wr_onehot[rd_addr_b]) begin
      rd_data_b = wr_data;
    end
    if (rd_addr_b == ZERO_ADDR) begin
      rd_data_b = '0;
    end
  end

endmodule

// File: tb/tb_regfile_32x64.sv
// ---------------------------------------------------------------------------
// tb_regfile_32x64
//
// Self-checking bench for regfile_32x64.
//
// Stimulus is applied one cycle at a time, just after a rising edge. Expected
// rd_data_a, rd_data_b and wr_onehot values are pushed to queues at that
// point. They are popped and compared on the following falling edge, before
// the write commits. A small reference model of the register contents is
// updated on each rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_32x64;

  localparam int DATA_W = 64;
  localparam int NREGS  = 32;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [4:0]        rd_addr_a;
  logic [4:0]        rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [NREGS-1:0]  wr_onehot;

  always #5 clk = ~clk;

  regfile_32x64 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_onehot (wr_onehot)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_b_q[$];
  logic [NREGS-1:0]  exp_oh_q[$];
  logic [DATA_W-1:0] model [NREGS];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent expected-read computation from the reference model.
  function automatic logic [DATA_W-1:0] model_rd(input logic [4:0] ra,
      input logic we, input logic [4:0] wa, input logic [DATA_W-1:0] wd);
    if (ra == 5'd31) return '0;
    if (we === 1'b1 && wa == ra) return wd;
    return model[ra];
  endfunction

  function automatic logic [NREGS-1:0] model_oh(input logic we, input logic [4:0] wa);
    logic [NREGS-1:0] one;
    one = 32'd1;
    if (we !== 1'b1 || wa == 5'd31) return '0;
    return one << wa;
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge. Drives one cycle, checks at the falling
  // edge, commits the model at the next rising edge, and returns #1 after it.
  task automatic apply(input logic we, input logic [4:0] wa,
                       input logic [DATA_W-1:0] wd, input logic [4:0] ra,
                       input logic [4:0] rb, input logic [DATA_W-1:0] ea,
                       input logic [DATA_W-1:0] eb, input logic [NREGS-1:0] eoh,
                       input string name);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    exp_q.push_back(ea);
    exp_b_q.push_back(eb);
    exp_oh_q.push_back(eoh);
    @(negedge clk);
    check($sformatf("%s rd_data_a", name), rd_data_a, exp_q.pop_front());
    check($sformatf("%s rd_data_b", name), rd_data_b, exp_b_q.pop_front());
    check($sformatf("%s wr_onehot", name), DATA_W'(wr_onehot), DATA_W'(exp_oh_q.pop_front()));
    @(posedge clk);
    if (reset_n === 1'b1 && we === 1'b1 && wa != 5'd31) model[wa] = wd;
    #1;
  endtask

  // Applies one cycle with expected values taken from the model.
  task automatic apply_model(input logic we, input logic [4:0] wa,
                             input logic [DATA_W-1:0] wd, input logic [4:0] ra,
                             input logic [4:0] rb, input string name);
    apply(we, wa, wd, ra, rb, model_rd(ra, we, wa, wd), model_rd(rb, we, wa, wd),
          model_oh(we, wa), name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              we;
    logic [4:0]        wa;
    logic [DATA_W-1:0] wd;
    logic [4:0]        ra;
    logic [4:0]        rb;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    logic [NREGS-1:0]  eoh;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic we, input logic [4:0] wa,
                         input logic [DATA_W-1:0] wd, input logic [4:0] ra,
                         input logic [4:0] rb, input logic [DATA_W-1:0] ea,
                         input logic [DATA_W-1:0] eb, input logic [NREGS-1:0] eoh);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
    v.ea = ea; v.eb = eb; v.eoh = eoh;
    vecs.push_back(v);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [DATA_W-1:0] v;
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, applied in order from the reset state.
    add_vec(0, 0,  0,                       5,  30, 0, 0, 32'h0);
    add_vec(1, 5,  64'h0123_4567_89AB_CDEF, 0,  1,  0, 0, 32'h0000_0020);
    add_vec(1, 30, 64'hFFFF_FFFF_FFFF_FFFF, 5,  0,  64'h0123_4567_89AB_CDEF, 0, 32'h4000_0000);
    add_vec(0, 0,  0,                       5,  30, 64'h0123_4567_89AB_CDEF,
            64'hFFFF_FFFF_FFFF_FFFF, 32'h0);
    add_vec(1, 7,  64'h11,                  0,  0,  0, 0, 32'h0000_0080);
    add_vec(1, 7,  64'h22,                  7,  7,  64'h22, 64'h22, 32'h0000_0080);
    add_vec(0, 0,  0,                       7,  7,  64'h22, 64'h22, 32'h0);
    add_vec(1, 31, 64'hDEAD,                31, 31, 0, 0, 32'h0);
    add_vec(0, 0,  0,                       31, 5,  0, 64'h0123_4567_89AB_CDEF, 32'h0);
    add_vec(1, 3,  64'h3333,                0,  0,  0, 0, 32'h0000_0008);
    add_vec(0, 3,  64'hBEEF,                3,  3,  64'h3333, 64'h3333, 32'h0);
    add_vec(0, 0,  0,                       3,  31, 64'h3333, 0, 32'h0);
    add_vec(0, 'x, 'x,                      3,  7,  64'h3333, 64'h22, 32'h0);

    foreach (vecs[k]) begin
      apply(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].ra, vecs[k].rb,
            vecs[k].ea, vecs[k].eb, vecs[k].eoh, $sformatf("vec%0d", k));
    end

    // Sweep: write X0..X30, then read back all (i, 30-i) pairs.
    for (int i = 0; i < 31; i++) begin
      v = ({32'd0, 32'(i)} << 32) | {32'd0, ~32'(i)};
      apply_model(1'b1, 5'(i), v, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  $sformatf("sweep_wr%0d", i));
    end
    for (int i = 0; i < 31; i++) begin
      v = ({32'd0, 32'(i)} << 32) | {32'd0, ~32'(i)};
      apply(1'b0, 5'd0, '0, 5'(i), 5'(30 - i), v,
            ({32'd0, 32'(30 - i)} << 32) | {32'd0, ~32'(30 - i)}, '0,
            $sformatf("sweep_rd%0d", i));
    end

    // Exhaustive one-hot decode with random data and bypass reads.
    for (int a = 0; a < NREGS; a++) begin
      v = {$urandom, $urandom};
      apply_model(1'b1, 5'(a), v, 5'(a), 5'($urandom_range(0, 31)),
                  $sformatf("onehot%0d", a));
    end

    // Reset asserted during a write: registers clear asynchronously, and
    // the write is dropped.
    wr_en     = 1'b1;
    wr_addr   = 5'd9;
    wr_data   = 64'hCAFE_F00D;
    rd_addr_a = 5'd10;
    rd_addr_b = 5'd31;
    #2;
    reset_n = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    @(negedge clk);
    check("rst_async rd_data_a", rd_data_a, '0);
    check("rst_async rd_data_b", rd_data_b, '0);
    check("rst_async wr_onehot", DATA_W'(wr_onehot), DATA_W'(32'h0000_0200));
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("rst_wr_en0 wr_onehot", DATA_W'(wr_onehot), '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREGS; i++) begin
      apply(1'b0, 5'd0, '0, 5'(i), 5'(31 - i), '0, '0, '0, $sformatf("rst_rd%0d", i));
    end

    // Register 9 must still be writable after reset.
    apply_model(1'b1, 5'd9, 64'h5A5A, 5'd0, 5'd9, "post_rst_wr");
    apply_model(1'b0, 5'd0, '0, 5'd9, 5'd9, "post_rst_rd");

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
